riscv_compressed_packer: RTL and testbench

Streaming RV32 → RVC instruction compressor and parcel packer for the RI5CY code-generation/patch path. Accepts uncompressed 32-bit instructions over a valid/ready handshake and replaces each eligible instruction with its 16-bit RVC equivalent. It packs the resulting 16/32-bit parcels little-endian into 32-bit aligned words for instruction memory. Output words are exactly what the compressed decoder expands back to the original RV32 stream.

---
 rtl/riscv_compressed_packer.sv | 140 ++++++++++++++
 tb/tb_riscv_compressed_packer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/riscv_compressed_packer.sv
// riscv_compressed_packer: streams RV32 instructions, compresses eligible ones to RVC, packs parcels into 32-bit words
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   instr_valid_i/instr_ready_o  input handshake, instr_i = RV32 instruction
//   flush_i                      end-of-stream pulse; pads a pending half-word with c.nop
//   word_valid_o/word_ready_i    output handshake, word_o = packed word (low half = earlier parcel)
//   flush_done_o                 pulse when a flush completes
//   illegal_o                    pulse when a non-32-bit encoding was dropped
//   cmp_cnt_o                    saturating count of compressed instructions
// Optional: define RISCV_CPACK_MEM_EN to compress lw/sw into c.lw/c.sw.
module riscv_compressed_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic        flush_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_o,
  output logic        flush_done_o,
  output logic        illegal_o,
  output logic [15:0] cmp_cnt_o
);
  typedef enum logic {RUN, FLUSH} state_e;
  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, emit;
  logic [15:0] res_q, res_d, cnt_q, c16;
  logic        res_v_q, res_v_d, done_q, done_d, illegal_q, is_c;
  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        imm6_ok, is_add, is_addi, slot_free, hs, legal, acc;
  assign opc = instr_i[6:0];
  assign rd  = instr_i[11:7];
  assign f3  = instr_i[14:12];
  assign rs1 = instr_i[19:15];
  assign rs2 = instr_i[24:20];
  assign f7  = instr_i[31:25];
  // I-immediate fits a signed 6-bit field when bits [11:5] are a pure sign extension
  assign imm6_ok = &instr_i[31:25] | ~|instr_i[31:25];
  assign is_add  = opc == 7'h33 && f3 == 3'b000 && f7 == 7'h00;
  assign is_addi = opc == 7'h13 && f3 == 3'b000;
  always_comb begin
    c16  = '0;
    is_c = 1'b1;
    if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0)
      c16 = {4'b1000, rd, rs2, 2'b10};
    else if (is_add && rs1 == rd && rd != 5'd0 && rs2 != 5'd0)
      c16 = {4'b1001, rd, rs2, 2'b10};
    else if (is_addi && rs1 == 5'd0 && rd != 5'd0 && imm6_ok)
      c16 = {3'b010, instr_i[25], rd, instr_i[24:20], 2'b01};
    else if (is_addi && rs1 == rd && rd != 5'd0 && imm6_ok && instr_i[25:20] != 6'd0)
      c16 = {3'b000, instr_i[25], rd, instr_i[24:20], 2'b01};
    else if (opc == 7'h67 && f3 == 3'b000 && rd == 5'd0 && instr_i[31:20] == 12'd0 && rs1 != 5'd0)
      c16 = {4'b1000, rs1, 5'd0, 2'b10};
    else if (instr_i == 32'h0010_0073)
      c16 = 16'h9002;
`ifdef RISCV_CPACK_MEM_EN
    // offset must be word aligned and below 128, registers in x8..x15
    else if (opc == 7'h03 && f3 == 3'b010 && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
             instr_i[31:27] == 5'd0 && instr_i[21:20] == 2'b00)
      c16 = {3'b010, instr_i[25:23], rs1[2:0], instr_i[22], instr_i[26], rd[2:0], 2'b00};
    else if (opc == 7'h23 && f3 == 3'b010 && rs2[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
             instr_i[31:27] == 5'd0 && instr_i[8:7] == 2'b00)
      c16 = {3'b110, instr_i[25], instr_i[11:10], rs1[2:0], instr_i[9], instr_i[26], rs2[2:0], 2'b00};
`endif
    else
      is_c = 1'b0;
  end
  assign slot_free     = !word_valid_q || word_ready_i;
  assign instr_ready_o = state_q == RUN && slot_free;
  assign hs            = instr_valid_i && instr_ready_o;
  assign legal         = &instr_i[1:0];
  assign acc           = hs && legal;
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    res_v_d = res_v_q;
    word_d  = word_q;
    emit    = 1'b0;
    done_d  = 1'b0;
    if (state_q == RUN) begin
      if (acc) begin
        if (!res_v_q && is_c) begin
          res_d   = c16;
          res_v_d = 1'b1;
        end else if (!res_v_q) begin
          word_d = instr_i;
          emit   = 1'b1;
        end else if (is_c) begin
          word_d  = {c16, res_q};
          emit    = 1'b1;
          res_v_d = 1'b0;
        end else begin
          word_d = {instr_i[15:0], res_q};
          emit   = 1'b1;
          res_d  = instr_i[31:16];
        end
      end
      if (flush_i) state_d = FLUSH;
    end else if (slot_free) begin
      // pad an orphan half-word with c.nop so the word decodes cleanly
      if (res_v_q) begin
        word_d  = {16'h0001, res_q};
        emit    = 1'b1;
        res_v_d = 1'b0;
      end
      done_d  = 1'b1;
      state_d = RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      res_q        <= '0;
      res_v_q      <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      word_valid_q <= slot_free ? emit : word_valid_q;
      res_q        <= res_d;
      res_v_q      <= res_v_d;
      done_q       <= done_d;
      illegal_q    <= hs && !legal;
      if (acc && is_c && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign flush_done_o = done_q;
  assign illegal_o    = illegal_q;
  assign cmp_cnt_o    = cnt_q;
endmodule

// File: tb/tb_riscv_compressed_packer.sv
// tb_riscv_compressed_packer: directed self-checking bench for riscv_compressed_packer
module tb_riscv_compressed_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] instr_i = '0;
  logic        flush_i = 1'b0;
  logic        word_valid_o;
  logic        word_ready_i = 1'b1;
  logic [31:0] word_o;
  logic        flush_done_o;
  logic        illegal_o;
  logic [15:0] cmp_cnt_o;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cmp = '0;
  riscv_compressed_packer dut (
    .clk(clk), .rst(rst),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
    .flush_i(flush_i),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i), .word_o(word_o),
    .flush_done_o(flush_done_o), .illegal_o(illegal_o), .cmp_cnt_o(cmp_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // present one instruction for exactly one cycle; returns at the following negedge
  task automatic send(input logic [31:0] ins);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    @(negedge clk);
    instr_valid_i = 1'b0;
  endtask
  task automatic pulse_flush();
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wv", word_valid_o, 0);
    chk("rst_word", word_o, 0);
    chk("rst_done", flush_done_o, 0);
    chk("rst_ill", illegal_o, 0);
    chk("rst_cnt", cmp_cnt_o, 0);
    chk("rst_rdy", instr_ready_o, 1);
    // c.addi then uncompressible lui, then flush pads the upper half of lui
    send(32'h0032_8293); exp_cmp++;
    chk("t1_nowd", word_valid_o, 0);
    send(32'h1234_50B7);
    chk("t1_wv", word_valid_o, 1);
    chk("t1_word", word_o, 32'h50B7_028D);
    pulse_flush();
    chk("t1_flush_rdy", instr_ready_o, 0);
    chk("t1_flush_wv0", word_valid_o, 0);
    @(negedge clk);
    chk("t1_pad_wv", word_valid_o, 1);
    chk("t1_pad", word_o, 32'h0001_1234);
    chk("t1_done", flush_done_o, 1);
    @(negedge clk);
    chk("t1_done_off", flush_done_o, 0);
    chk("t1_wv_off", word_valid_o, 0);
    chk("t1_cnt", cmp_cnt_o, exp_cmp);
    // c.mv + c.ebreak pack into one word
    send(32'h00B0_0533); exp_cmp++;
    chk("t2_nowd", word_valid_o, 0);
    send(32'h0010_0073); exp_cmp++;
    chk("t2_wv", word_valid_o, 1);
    chk("t2_word", word_o, 32'h9002_852E);
    chk("t2_cnt", cmp_cnt_o, exp_cmp);
    @(negedge clk);
    // out-of-range addi passes through; stall downstream
    send(32'h0642_8293);
    chk("t3_wv", word_valid_o, 1);
    chk("t3_word", word_o, 32'h0642_8293);
    word_ready_i = 1'b0;
    #1;
    chk("t3_rdy_comb", instr_ready_o, 0);
    for (int i = 0; i < 5; i++) begin
      instr_valid_i = 1'b1;
      instr_i       = 32'h0000_8067;
      @(negedge clk);
      chk("t3_hold_wv", word_valid_o, 1);
      chk("t3_hold_word", word_o, 32'h0642_8293);
      chk("t3_hold_rdy", instr_ready_o, 0);
    end
    instr_valid_i = 1'b0;
    word_ready_i  = 1'b1;
    #1;
    chk("t3_rdy_back", instr_ready_o, 1);
    @(negedge clk);
    chk("t3_drain", word_valid_o, 0);
    chk("t3_cnt", cmp_cnt_o, exp_cmp);
    // lw x8,4(x9) twice
`ifdef RISCV_CPACK_MEM_EN
    send(32'h0044_A403); exp_cmp++;
    chk("t4_nowd", word_valid_o, 0);
    send(32'h0044_A403); exp_cmp++;
    chk("t4_wv", word_valid_o, 1);
    chk("t4_word", word_o, 32'h40C0_40C0);
`else
    send(32'h0044_A403);
    chk("t4_wv_a", word_valid_o, 1);
    chk("t4_word_a", word_o, 32'h0044_A403);
    send(32'h0044_A403);
    chk("t4_wv_b", word_valid_o, 1);
    chk("t4_word_b", word_o, 32'h0044_A403);
`endif
    chk("t4_cnt", cmp_cnt_o, exp_cmp);
    @(negedge clk);
    // illegal input between two halves leaves residue intact
    send(32'h0032_8293); exp_cmp++;
    send(32'h0000_0001);
    chk("t5_ill", illegal_o, 1);
    chk("t5_nowd", word_valid_o, 0);
    @(negedge clk);
    chk("t5_ill_off", illegal_o, 0);
    send(32'h0010_0073); exp_cmp++;
    chk("t5_word", word_o, 32'h9002_028D);
    chk("t5_cnt", cmp_cnt_o, exp_cmp);
    // c.li imm=-32 boundary, addi imm=0 not compressed, addi imm=-33 not compressed, c.jr
    send(32'hFE00_0093); exp_cmp++;
    send(32'h0002_8293);
    chk("t6_word_a", word_o, 32'h8293_5081);
    send(32'h0000_8067); exp_cmp++;
    chk("t6_word_b", word_o, 32'h8082_0002);
    send(32'hFDF0_0093);
    chk("t6_word_c", word_o, 32'hFDF0_0093);
    send(32'h0062_82B3); exp_cmp++;
    send(32'h0010_0073); exp_cmp++;
    chk("t6_word_d", word_o, 32'h9002_929A);
    chk("t6_cnt", cmp_cnt_o, exp_cmp);
    // reset while in FLUSH with residue pending
    send(32'h0032_8293);
    pulse_flush();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7_wv", word_valid_o, 0);
    chk("t7_word", word_o, 0);
    chk("t7_done", flush_done_o, 0);
    chk("t7_cnt", cmp_cnt_o, 0);
    chk("t7_rdy", instr_ready_o, 1);
    @(negedge clk);
    chk("t7_wv2", word_valid_o, 0);
    chk("t7_done2", flush_done_o, 0);
    pulse_flush();
    chk("t7_ef_rdy", instr_ready_o, 0);
    @(negedge clk);
    chk("t7_ef_done", flush_done_o, 1);
    chk("t7_ef_nowd", word_valid_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
